// File: rtl/demultiplexer_1_to_3_pkg.sv
// Shared selector encodings, channel count and selector decode helper for the 1-to-3 demux.
// Latency: none (constants and a pure function only).
// Backpressure: not applicable.
package demux_pkg;

  localparam int NUM_CH = 3;

  localparam logic [1:0] SEL_CH0     = 2'b00;
  localparam logic [1:0] SEL_CH1     = 2'b01;
  localparam logic [1:0] SEL_CH2     = 2'b10;
  localparam logic [1:0] SEL_INVALID = 2'b11;

  // One-hot channel decode; the invalid encoding maps to no channel.
  function automatic logic [NUM_CH-1:0] sel_onehot(input logic [1:0] sel);
    logic [NUM_CH-1:0] oh;
    oh = '0;
    case (sel)
      SEL_CH0: oh = 3'b001;
      SEL_CH1: oh = 3'b010;
      SEL_CH2: oh = 3'b100;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/demultiplexer_1_to_3_if.sv
// Producer-side stream plus three consumer channels of the 1-to-3 demux.
// Latency: none (wiring only).
// Backpressure: In_Ready_o toward the producer, Out_Ready_i per consumer channel.
interface demultiplexer_1_to_3_if
  import demux_pkg::*;
#(
  parameter int NBits = 32
);

  logic [1:0]        Selector_i;
  logic              In_Valid_i;
  logic [NBits-1:0]  In_Data_i;
  logic              In_Ready_o;
  logic [NUM_CH-1:0] Out_Valid_o;
  logic [NBits-1:0]  Out_Data_0_o;
  logic [NBits-1:0]  Out_Data_1_o;
  logic [NBits-1:0]  Out_Data_2_o;
  logic [NUM_CH-1:0] Out_Ready_i;

  // Environment side: drives the input stream and the consumer readies.
  modport master (
    output Selector_i, In_Valid_i, In_Data_i, Out_Ready_i,
    input  In_Ready_o, Out_Valid_o, Out_Data_0_o, Out_Data_1_o, Out_Data_2_o
  );

  // Demux side.
  modport slave (
    input  Selector_i, In_Valid_i, In_Data_i, Out_Ready_i,
    output In_Ready_o, Out_Valid_o, Out_Data_0_o, Out_Data_1_o, Out_Data_2_o
  );

endinterface

// File: rtl/demultiplexer_1_to_3_slot.sv
// One-entry valid/data output buffer for a single demux channel.
// Latency: 1 cycle from load to o_vld.
// Backpressure: holds its word while i_drain_rdy is low; accepts a refill on the draining edge.
module Demux_Output_Slot #(
  parameter int NBits = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [NBits-1:0] i_load_dat,
  input  logic             i_drain_rdy,
  output logic             o_vld,
  output logic [NBits-1:0] o_dat,
  output logic             o_can_accept
);

  logic             r_vld;
  logic [NBits-1:0] r_dat;

  // Load wins over drain so a same-edge drain and refill keeps the slot valid.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_vld <= 1'b0;
      r_dat <= '0;
    end else if (i_load) begin
      r_vld <= 1'b1;
      r_dat <= i_load_dat;
    end else if (i_drain_rdy) begin
      r_vld <= 1'b0;
    end
  end

  // Free now, or freed on this edge by the consumer taking the current word.
  assign o_can_accept = ~r_vld | i_drain_rdy;
  assign o_vld        = r_vld;
  assign o_dat        = r_dat;

endmodule

// File: rtl/demultiplexer_1_to_3.sv
// Routes one valid/ready stream to three buffered channels by a 2-bit selector; optional drop counter under DEMUX_DROP_COUNT_EN.
// Latency: 1 cycle from input acceptance to Out_Valid_o on the selected channel.
// Backpressure: stalls only when the selected slot is full and its consumer is not ready; selector 11 always accepted and discarded.
module demultiplexer_1_to_3
  import demux_pkg::*;
#(
  parameter int NBits   = 32,
  parameter int CntBits = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  demultiplexer_1_to_3_if.slave bus
`ifdef DEMUX_DROP_COUNT_EN
  ,
  output logic [CntBits-1:0]   Drop_Count_o
`endif
);

  logic [NUM_CH-1:0] w_sel_oh;
  logic [NUM_CH-1:0] w_can_accept;
  logic [NUM_CH-1:0] w_load;
  logic [NUM_CH-1:0] w_vld;
  logic [NBits-1:0]  w_dat [NUM_CH];
  logic              w_sel_invalid;
  logic              w_in_rdy;

  assign w_sel_oh      = sel_onehot(bus.Selector_i);
  assign w_sel_invalid = (bus.Selector_i == SEL_INVALID);

  // Ready depends only on selector and the addressed slot, never on In_Valid_i.
  assign w_in_rdy       = w_sel_invalid | (|(w_sel_oh & w_can_accept));
  assign bus.In_Ready_o = w_in_rdy;

  assign w_load = w_sel_oh & {NUM_CH{bus.In_Valid_i & w_in_rdy}};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
    Demux_Output_Slot #(.NBits(NBits)) u_slot (
      .i_clk        (clk_i),
      .i_rst_n      (rst_n_i),
      .i_load       (w_load[g]),
      .i_load_dat   (bus.In_Data_i),
      .i_drain_rdy  (bus.Out_Ready_i[g]),
      .o_vld        (w_vld[g]),
      .o_dat        (w_dat[g]),
      .o_can_accept (w_can_accept[g])
    );
  end

  assign bus.Out_Valid_o  = w_vld;
  assign bus.Out_Data_0_o = w_dat[0];
  assign bus.Out_Data_1_o = w_dat[1];
  assign bus.Out_Data_2_o = w_dat[2];

`ifdef DEMUX_DROP_COUNT_EN
  logic [CntBits-1:0] r_drop_cnt;

  // Count accepted invalid-selector transfers, saturating at all-ones.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_drop_cnt <= '0;
    end else if (bus.In_Valid_i && w_sel_invalid && (r_drop_cnt != '1)) begin
      r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  assign Drop_Count_o = r_drop_cnt;
`endif

endmodule

// File: tb/tb_demultiplexer_1_to_3.sv
module tb_demultiplexer_1_to_3;

`ifdef DEMUX_DROP_COUNT_EN
  localparam int CNT_W = 2;
`else
  localparam int CNT_W = 8;
`endif

  logic clk_i;
  logic rst_n_i;

  demultiplexer_1_to_3_if #(.NBits(32)) u_if ();

`ifdef DEMUX_DROP_COUNT_EN
  logic [CNT_W-1:0] drop_cnt;
`endif

  demultiplexer_1_to_3 #(.NBits(32), .CntBits(CNT_W)) u_dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .bus     (u_if.slave)
`ifdef DEMUX_DROP_COUNT_EN
    ,
    .Drop_Count_o (drop_cnt)
`endif
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  logic [31:0] out_d [3];
  assign out_d[0] = u_if.Out_Data_0_o;
  assign out_d[1] = u_if.Out_Data_1_o;
  assign out_d[2] = u_if.Out_Data_2_o;

  typedef struct {
    logic        rst_n;
    logic        vld;
    logic [1:0]  sel;
    logic [31:0] dat;
    logic [2:0]  ordy;
    logic        chk;
    logic        exp_rdy;
    logic [2:0]  exp_vld;
    logic [1:0]  exp_drop;
    logic        zchk;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] sb [3][$];
  int          n_cmp  = 0;
  int          n_fail = 0;

  function automatic vec_t mk(logic rst_n, logic vld, logic [1:0] sel, logic [31:0] dat,
                              logic [2:0] ordy, logic chk, logic exp_rdy, logic [2:0] exp_vld,
                              logic [1:0] exp_drop, logic zchk);
    vec_t v;
    v.rst_n = rst_n; v.vld = vld; v.sel = sel; v.dat = dat; v.ordy = ordy;
    v.chk = chk; v.exp_rdy = exp_rdy; v.exp_vld = exp_vld; v.exp_drop = exp_drop; v.zchk = zchk;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    rst_n_i           = v.rst_n;
    u_if.In_Valid_i   = v.vld;
    u_if.Selector_i   = v.sel;
    u_if.In_Data_i    = v.dat;
    u_if.Out_Ready_i  = v.ordy;
  endtask

  initial begin
    int w;
    rst_n_i          = 1'b0;
    u_if.In_Valid_i  = 1'b0;
    u_if.Selector_i  = 2'b00;
    u_if.In_Data_i   = '0;
    u_if.Out_Ready_i = 3'b000;

    // reset with In_Valid_i high
    tbl.push_back(mk(0, 1, 0, 32'hAA,       3'b111, 0, 1, 3'b000, 0, 0));
    tbl.push_back(mk(0, 1, 0, 32'hAA,       3'b111, 1, 1, 3'b000, 0, 1));
    // single routing to ch1, then drain
    tbl.push_back(mk(1, 1, 1, 32'hDEADBEEF, 3'b111, 1, 1, 3'b000, 0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        3'b111, 1, 1, 3'b010, 0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        3'b111, 1, 1, 3'b000, 0, 0));
    // backpressure on ch0 while ch2 still accepts
    tbl.push_back(mk(1, 1, 0, 32'h11,       3'b000, 1, 1, 3'b000, 0, 0));
    tbl.push_back(mk(1, 1, 0, 32'h33,       3'b000, 1, 0, 3'b001, 0, 0));
    tbl.push_back(mk(1, 1, 2, 32'h22,       3'b000, 1, 1, 3'b001, 0, 0));
    tbl.push_back(mk(1, 1, 0, 32'h33,       3'b000, 1, 0, 3'b101, 0, 0));
    tbl.push_back(mk(1, 1, 0, 32'h33,       3'b001, 1, 1, 3'b101, 0, 0));
    tbl.push_back(mk(1, 0, 2, 32'h0,        3'b000, 1, 0, 3'b101, 0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        3'b111, 1, 1, 3'b101, 0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        3'b111, 1, 1, 3'b000, 0, 0));
    // back-to-back stream 1..8 into ch2
    for (int j = 1; j <= 8; j++)
      tbl.push_back(mk(1, 1, 2, 32'(j), 3'b100, 1, 1, (j == 1) ? 3'b000 : 3'b100, 0, 0));
    tbl.push_back(mk(1, 0, 2, 32'h0,        3'b100, 1, 1, 3'b100, 0, 0));
    tbl.push_back(mk(1, 0, 3, 32'h0,        3'b000, 1, 1, 3'b000, 0, 0));
    // invalid selector: accepted, discarded, counter saturates
    for (int j = 0; j < 5; j++)
      tbl.push_back(mk(1, 1, 3, 32'h5A + 32'(j), 3'b000, 1, 1, 3'b000, (j > 3) ? 2'd3 : 2'(j), 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        3'b000, 1, 1, 3'b000, 3, 0));
    // fill all slots, then reset mid-operation
    tbl.push_back(mk(1, 1, 0, 32'hA0,       3'b000, 1, 1, 3'b000, 3, 0));
    tbl.push_back(mk(1, 1, 1, 32'hA1,       3'b000, 1, 1, 3'b001, 3, 0));
    tbl.push_back(mk(1, 1, 2, 32'hA2,       3'b000, 1, 1, 3'b011, 3, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        3'b000, 1, 0, 3'b111, 3, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        3'b000, 1, 1, 3'b000, 0, 1));
    // traffic resumes cleanly after reset
    tbl.push_back(mk(1, 1, 0, 32'h77,       3'b001, 1, 1, 3'b000, 0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        3'b001, 1, 1, 3'b001, 0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        3'b000, 1, 1, 3'b000, 0, 0));

    @(posedge clk_i); #1;
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      @(negedge clk_i);
      if (tbl[i].chk) begin
        check($sformatf("in_ready[%0d]", i), 32'(u_if.In_Ready_o), 32'(tbl[i].exp_rdy));
        check($sformatf("out_valid[%0d]", i), 32'(u_if.Out_Valid_o), 32'(tbl[i].exp_vld));
`ifdef DEMUX_DROP_COUNT_EN
        check($sformatf("drop_count[%0d]", i), 32'(drop_cnt), 32'(tbl[i].exp_drop));
`endif
        if (tbl[i].zchk)
          for (int k = 0; k < 3; k++)
            check($sformatf("reset_data_ch%0d[%0d]", k, i), out_d[k], 32'h0);
        // scoreboard: the word at the head of each channel queue must be on the output
        for (int k = 0; k < 3; k++) begin
          if (tbl[i].exp_vld[k]) begin
            if (sb[k].size() == 0) begin
              n_cmp++; n_fail++;
              $display("FAIL sb_underflow ch%0d[%0d]: got data %h expected no word", k, i, out_d[k]);
            end else begin
              check($sformatf("ch%0d_data[%0d]", k, i), out_d[k], sb[k][0]);
              if (tbl[i].rst_n && tbl[i].ordy[k]) void'(sb[k].pop_front());
            end
          end
        end
      end
      if (!tbl[i].rst_n) begin
        for (int k = 0; k < 3; k++) sb[k].delete();
      end else if (tbl[i].vld && tbl[i].exp_rdy && tbl[i].sel != 2'b11) begin
        sb[tbl[i].sel].push_back(tbl[i].dat);
      end
      @(posedge clk_i); #1;
    end

    check("sb_leftover", 32'(sb[0].size() + sb[1].size() + sb[2].size()), 32'h0);
    check("hold_after_drain", out_d[0], 32'h77);

    // ch1 word under backpressure, bounded wait for its valid
    u_if.Selector_i = 2'b01; u_if.In_Valid_i = 1'b1; u_if.In_Data_i = 32'hCAFEF00D;
    u_if.Out_Ready_i = 3'b000;
    @(posedge clk_i); #1;
    u_if.In_Valid_i = 1'b0;
    w = 0;
    while (!u_if.Out_Valid_o[1] && w < 4) begin
      @(posedge clk_i); #1;
      w++;
    end
    check("ch1_valid_wait", 32'(u_if.Out_Valid_o[1]), 32'h1);
    check("ch1_data_cafe", out_d[1], 32'hCAFEF00D);
    check("rdy_ch1_full", 32'(u_if.In_Ready_o), 32'h0);
    u_if.In_Valid_i = 1'b1; u_if.In_Data_i = 32'h0BADCAFE;
    #1;
    check("rdy_indep_of_valid", 32'(u_if.In_Ready_o), 32'h0);
    u_if.Out_Ready_i = 3'b010;
    #1;
    check("rdy_passthrough", 32'(u_if.In_Ready_o), 32'h1);
    // same-edge drain and refill keeps ch1 valid with the new word
    @(posedge clk_i); #1;
    u_if.In_Valid_i = 1'b0;
    check("refill_valid", 32'(u_if.Out_Valid_o), 32'h2);
    check("refill_data", out_d[1], 32'h0BADCAFE);
    @(posedge clk_i); #1;
    check("drained_valid", 32'(u_if.Out_Valid_o), 32'h0);
    check("drained_hold", out_d[1], 32'h0BADCAFE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
